// File: rtl/rr_decoder_sched.sv
// Round-robin owner scheduler driving a decoder4x16 enable/select pair; one-cycle gap between owners.
// Optional grant-hold timeout compiled in with RR_TIMEOUT_EN (limit set by MAX_HOLD).
module rr_decoder_sched #(
   parameter int MAX_HOLD = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] req,
   input  logic        done,
   output logic        dec_enable,
   output logic [3:0]  dec_sel,
   output logic        busy,
   output logic        timeout
);

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

   if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
      $error("rr_decoder_sched: MAX_HOLD must be 1..255");
   end

   state_t      state_q, state_d;
   logic [3:0]  ptr_q, ptr_d;
   logic [3:0]  sel_q, sel_d;
   logic        en_q, en_d;
   logic        to_q, to_d;
   logic        win_vld;
   logic [3:0]  win_idx;
   logic [3:0]  cand;
   logic        expire;

   // Scan from the farthest offset down so the offset closest to ptr is the last to land.
   always_comb begin
      win_vld = 1'b0;
      win_idx = ptr_q;
      cand    = ptr_q;
      for (int i = 15; i >= 0; i--) begin
         cand = ptr_q + 4'(i);
         if (req[cand]) begin
            win_vld = 1'b1;
            win_idx = cand;
         end
      end
   end

`ifdef RR_TIMEOUT_EN
   logic [7:0] cnt_q, cnt_d;

   assign cnt_d  = (state_q == S_GRANT) ? cnt_q + 8'd1 : 8'd0;
   assign expire = (state_q == S_GRANT) && (cnt_q == 8'(MAX_HOLD - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= 8'd0;
      else     cnt_q <= cnt_d;
   end
`else
   assign expire = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      to_d    = 1'b0;
      case (state_q)
         S_IDLE, S_GAP: begin
            if (win_vld) begin
               state_d = S_GRANT;
               sel_d   = win_idx;
               ptr_d   = win_idx + 4'd1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_GRANT: begin
            // A genuine release (done or withdrawal) takes precedence over expiry.
            if (done || !req[sel_q]) begin
               state_d = S_GAP;
            end else if (expire) begin
               state_d = S_GAP;
               to_d    = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign en_d = (state_d == S_GRANT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         ptr_q   <= 4'd0;
         sel_q   <= 4'd0;
         en_q    <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         en_q    <= en_d;
         to_q    <= to_d;
      end
   end

   assign dec_enable = en_q;
   assign busy       = en_q;
   assign dec_sel    = sel_q;
   assign timeout    = to_q;

endmodule

// File: tb/tb_rr_decoder_sched.sv
// Directed + random checks of rr_decoder_sched against a cycle-level owner/pointer model.
module tb_rr_decoder_sched;

   localparam int MAX_HOLD = 4;
`ifdef RR_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] req;
   logic        done;
   logic        dec_enable;
   logic [3:0]  dec_sel;
   logic        busy;
   logic        timeout;

   int n_chk = 0;
   int n_fail = 0;

   // model: 0 idle, 1 owned, 2 gap
   int m_st, m_ptr, m_own, m_held;
   bit m_to;

   rr_decoder_sched #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk(clk), .rst(rst), .req(req), .done(done),
      .dec_enable(dec_enable), .dec_sel(dec_sel), .busy(busy), .timeout(timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] onehot();
      logic [15:0] v;
      v = 16'h0;
      if (dec_enable) v[dec_sel] = 1'b1;
      return v;
   endfunction

   task automatic model_reset();
      m_st = 0; m_ptr = 0; m_own = 0; m_held = 0; m_to = 0;
   endtask

   task automatic model_edge(input logic [15:0] r, input logic d);
      m_to = 0;
      if (m_st == 1) begin
         if (d || !r[m_own]) m_st = 2;
         else if (TO_EN && m_held == MAX_HOLD - 1) begin
            m_st = 2;
            m_to = 1;
         end else m_held++;
      end else begin
         int w;
         w = -1;
         for (int k = 0; k < 16; k++)
            if (w < 0 && r[(m_ptr + k) % 16]) w = (m_ptr + k) % 16;
         if (w >= 0) begin
            m_st = 1; m_own = w; m_ptr = (w + 1) % 16; m_held = 0;
         end else m_st = 0;
      end
   endtask

   task automatic check_model();
      chk("dec_enable", 32'(dec_enable), 32'(m_st == 1));
      chk("busy", 32'(busy), 32'(m_st == 1));
      chk("timeout", 32'(timeout), 32'(m_to));
      if (m_st == 1) chk("dec_sel", 32'(dec_sel), 32'(m_own));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge(req, done);
      #1;
      check_model();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      model_reset();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; req = 16'h0; done = 1'b0;
      model_reset();
      @(posedge clk); #1;
      chk("rst_en", 32'(dec_enable), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_sel", 32'(dec_sel), 32'd0);
      chk("rst_to", 32'(timeout), 32'd0);
      rst = 1'b0;

      // single requester 3, then release
      req = 16'h0008; step();
      chk("r3_sel", 32'(dec_sel), 32'd3);
      chk("r3_dec", 32'(onehot()), 32'h0008);
      done = 1'b1; step();
      chk("r3_gap", 32'(dec_enable), 32'd0);
      req = 16'h0; done = 1'b0; step();
      chk("r3_idle", 32'(busy), 32'd0);

      // full rotation with done held high
      do_reset();
      req = 16'hFFFF; done = 1'b1;
      for (int i = 0; i < 15; i++) begin
         step(); chk("rot_sel", 32'(dec_sel), 32'(i));
         step(); chk("rot_gap", 32'(dec_enable), 32'd0);
      end
      step(); chk("rot_15", 32'(dec_sel), 32'd15);
      req = 16'h8001;
      step(); chk("wrap_gap", 32'(dec_enable), 32'd0);
      step(); chk("wrap_0", 32'(dec_sel), 32'd0);
      step();
      step(); chk("wrap_15", 32'(dec_sel), 32'd15);
      req = 16'h0; done = 1'b0;
      step(); step();

      // owner withdraws without done
      req = 16'h0020; step();
      chk("wd_sel", 32'(dec_sel), 32'd5);
      step(); chk("wd_hold", 32'(dec_enable), 32'd1);
      req = 16'h0; step();
      chk("wd_gap", 32'(dec_enable), 32'd0);
      chk("wd_to", 32'(timeout), 32'd0);
      step();

      // async reset mid-grant, then search restarts at 0
      req = 16'h0010; step();
      chk("ar_pre", 32'(dec_enable), 32'd1);
      #1 rst = 1'b1;
      #1 chk("ar_en", 32'(dec_enable), 32'd0);
      chk("ar_busy", 32'(busy), 32'd0);
      model_reset();
      @(posedge clk); #1 rst = 1'b0;
      req = 16'h0011; step();
      chk("ar_sel", 32'(dec_sel), 32'd0);
      done = 1'b1; step();
      req = 16'h0; done = 1'b0; step();

      // hold limit
      do_reset();
      req = 16'h0002;
      for (int i = 0; i < 4; i++) begin
         step(); chk("hold_en", 32'(dec_enable), 32'd1);
      end
      step();
`ifdef RR_TIMEOUT_EN
      chk("to_pulse", 32'(timeout), 32'd1);
      chk("to_en", 32'(dec_enable), 32'd0);
      step(); chk("to_regrant", 32'(timeout), 32'd0);
      step(); step(); step();
      done = 1'b1; step();
      chk("to_done_wins", 32'(timeout), 32'd0);
      chk("to_done_gap", 32'(dec_enable), 32'd0);
      done = 1'b0;
`else
      chk("nolimit_en", 32'(dec_enable), 32'd1);
      chk("nolimit_to", 32'(timeout), 32'd0);
`endif
      req = 16'h0; step(); step();

      // random traffic
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(7) == 0)
            req = ($urandom_range(1) == 0) ? 16'($urandom) : 16'($urandom & $urandom & $urandom);
         done = ($urandom_range(3) == 0);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
